uart_packet_tx: RTL and testbench

//  Transmit-side framer for the board-link UART packet protocol. Sends header bytes ADDR, CTRL, LEN,

---
 rtl/uart_packet_tx_if.sv | 28 ++
 rtl/uart_packet_tx.sv | 179 +++++++++++++++++
 tb/tb_uart_packet_tx.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_packet_tx_if.sv
// Purpose : handshake/bus bundle for the UART packet transmitter.
// Signals : start/addr/ctrl/len  - packet request and header bytes
//           data_in/data_valid/data_ready - upstream body byte stream
//           txd/busy/byte_done/pkt_done    - serial line and status
// Modports: master = packet builder side, slave = transmitter side.
interface uart_packet_tx_if;
    logic       start;
    logic [7:0] addr;
    logic [7:0] ctrl;
    logic [7:0] len;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       txd;
    logic       busy;
    logic       byte_done;
    logic       pkt_done;

    modport master (
        output start, addr, ctrl, len, data_in, data_valid,
        input  data_ready, txd, busy, byte_done, pkt_done
    );

    modport slave (
        input  start, addr, ctrl, len, data_in, data_valid,
        output data_ready, txd, busy, byte_done, pkt_done
    );
endinterface

// File: rtl/uart_packet_tx.sv
// Purpose : transmit framer for the board-link UART packet protocol.
//           Sends ADDR, CTRL, LEN header bytes back to back, then
//           2*LEN+4 body bytes pulled from a valid/ready stream, each as
//           an 8N1 frame, LSB first.
// Ports   : clk_i  - system clock, posedge
//           rst_ni - asynchronous active-low reset
//           bus    - uart_packet_tx_if.slave (request, body stream, txd,
//                    busy, byte_done, pkt_done)
// Params  : CLKS_PER_BIT - clocks per UART bit (>= 2)
module uart_packet_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    uart_packet_tx_if.slave   bus
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_FETCH
    } state_e;

    typedef enum logic [1:0] {
        PH_HDR0, PH_HDR1, PH_HDR2, PH_BODY
    } phase_e;

    state_e        state_q, state_d;
    phase_e        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    ctrl_q, ctrl_d;
    logic [7:0]    len_q, len_d;
    logic [9:0]    body_q, body_d;
    logic          byte_done_q, byte_done_d;
    logic          pkt_done_q, pkt_done_d;

    logic          bit_end;
    logic          accept;

    assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));
    // A start landing in the pkt_done cycle is treated as arriving while
    // the previous packet is still in flight, so it is dropped.
    assign accept  = bus.start && !pkt_done_q;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_START;
            S_START: if (bit_end) state_d = S_DATA;
            S_DATA:  if (bit_end && bit_q == 3'd7) state_d = S_STOP;
            S_STOP: begin
                if (bit_end) begin
                    unique case (phase_q)
                        PH_HDR0, PH_HDR1: state_d = S_START;
                        PH_HDR2:          state_d = S_FETCH;
                        default:          state_d = (body_q == 10'd1) ? S_IDLE : S_FETCH;
                    endcase
                end
            end
            S_FETCH: if (bus.data_valid) state_d = S_START;
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- datapath
    always_comb begin
        phase_d     = phase_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        ctrl_d      = ctrl_q;
        len_d       = len_q;
        body_d      = body_q;
        byte_done_d = 1'b0;
        pkt_done_d  = 1'b0;

        // Bit timer restarts on every state entry and idles at 0 where no
        // bit is being timed.
        if (state_d != state_q || bit_end || state_q == S_IDLE || state_q == S_FETCH)
            cnt_d = '0;
        else
            cnt_d = cnt_q + 1'b1;

        unique case (state_q)
            S_IDLE: begin
                bit_d = 3'd0;
                if (accept) begin
                    shift_d = bus.addr;
                    ctrl_d  = bus.ctrl;
                    len_d   = bus.len;
                    phase_d = PH_HDR0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;   // wraps to 0 after bit 7
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    byte_done_d = 1'b1;
                    unique case (phase_q)
                        PH_HDR0: begin
                            shift_d = ctrl_q;
                            phase_d = PH_HDR1;
                        end
                        PH_HDR1: begin
                            shift_d = len_q;
                            phase_d = PH_HDR2;
                        end
                        PH_HDR2: body_d = {1'b0, len_q, 1'b0} + 10'd4;
                        default: begin
                            body_d     = body_q - 10'd1;
                            pkt_done_d = (body_q == 10'd1);
                        end
                    endcase
                end
            end
            S_FETCH: begin
                if (bus.data_valid) begin
                    shift_d = bus.data_in;
                    phase_d = PH_BODY;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q     <= PH_HDR0;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'd0;
            ctrl_q      <= 8'd0;
            len_q       <= 8'd0;
            body_q      <= 10'd0;
            byte_done_q <= 1'b0;
            pkt_done_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            ctrl_q      <= ctrl_d;
            len_q       <= len_d;
            body_q      <= body_d;
            byte_done_q <= byte_done_d;
            pkt_done_q  <= pkt_done_d;
        end
    end

    // --------------------------------------------------------------- outputs
    // txd and data_ready decode registered state only, so reset forces the
    // line high immediately and data_valid never reaches data_ready.
    always_comb begin
        bus.txd        = 1'b1;
        bus.data_ready = 1'b0;
        unique case (state_q)
            S_START: bus.txd        = 1'b0;
            S_DATA:  bus.txd        = shift_q[0];
            S_FETCH: bus.data_ready = 1'b1;
            default: ;
        endcase
        bus.busy      = (state_q != S_IDLE);
        bus.byte_done = byte_done_q;
        bus.pkt_done  = pkt_done_q;
    end

endmodule

// File: tb/tb_uart_packet_tx.sv
module tb_uart_packet_tx;
    localparam int CPB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_packet_tx_if bus ();

    uart_packet_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] ctrl;
        logic [7:0] len;
        logic [7:0] base;       // first body byte, later bytes increment
        int         stall;      // FETCH cycles with data_valid held low
        bit         frame0;     // check raw txd waveform of first frame
        bit         repulse;    // pulse start again during CTRL frame
        bit         start_done; // pulse start in the pkt_done cycle
        int         frames;
        int         hs;
        int         cycles;     // accept edge to pkt_done edge
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- line monitor: pulse counters + 8N1 decoder
    int         bd_cnt = 0, pd_cnt = 0, rx_cnt = 0, fe_cnt = 0;
    logic [7:0] rx_buf [0:1023];
    logic       rx_act = 1'b0;
    int         rx_t   = 0;
    logic [7:0] rx_sh  = 8'h00;

    initial forever begin
        @(negedge clk);
        if (bus.byte_done === 1'b1) bd_cnt++;
        if (bus.pkt_done === 1'b1)  pd_cnt++;
        if (!rst_n) rx_act = 1'b0;
        else if (!rx_act) begin
            if (bus.txd === 1'b0) begin
                rx_act = 1'b1;
                rx_t   = 0;
            end
        end else begin
            rx_t++;
            if (rx_t % CPB == 1 && rx_t >= CPB + 1 && rx_t <= 8 * CPB + 1)
                rx_sh = {bus.txd, rx_sh[7:1]};
            if (rx_t == 9 * CPB + 1) begin
                if (bus.txd !== 1'b1) fe_cnt++;
                rx_buf[rx_cnt % 1024] = rx_sh;
                rx_cnt++;
                rx_act = 1'b0;
            end
        end
    end

    // ---------------- body byte source
    logic       src_en   = 1'b0;
    logic       src_hold = 1'b0;
    logic [7:0] src_base = 8'h00;
    int         hs_cnt   = 0;
    int         hs_base  = 0;

    initial begin
        bus.data_valid = 1'b0;
        bus.data_in    = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.data_valid === 1'b1 && bus.data_ready === 1'b1) hs_cnt++;
            @(posedge clk);
            #1;
            bus.data_in    = src_base + 8'(hs_cnt - hs_base);
            bus.data_valid = src_en && !src_hold;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- one packet from a table record
    task automatic run_pkt(input vec_t v, input int id);
        int         rx0, bd0, pd0, fe0, k, c0;
        logic [9:0] pat;
        logic       ok;
        logic [7:0] expb;

        @(negedge clk);
        rx0 = rx_cnt; bd0 = bd_cnt; pd0 = pd_cnt; fe0 = fe_cnt;
        hs_base  = hs_cnt;
        src_base = v.base;
        src_hold = (v.stall != 0);
        src_en   = 1'b1;

        @(posedge clk); #1;
        bus.addr = v.addr; bus.ctrl = v.ctrl; bus.len = v.len; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        // header must already be latched; these must not leak into the packet
        bus.addr = ~v.addr; bus.ctrl = ~v.ctrl; bus.len = ~v.len;
        @(negedge clk);
        chk($sformatf("v%0d accept busy", id), 32'(bus.busy), 32'd1);
        c0 = cyc;
        k  = 0;

        if (v.frame0) begin
            ok  = 1'b1;
            pat = 10'b11_0100_1010;  // start, 1,0,1,0,0,1,0,1 (0xA5 LSB first), stop
            for (int j = 0; j < 10 * CPB; j++) begin
                if (bus.txd !== pat[j / CPB]) ok = 1'b0;
                @(negedge clk);
                k++;
            end
            chk($sformatf("v%0d frame0 txd pattern", id), 32'(ok), 32'd1);
        end

        if (v.stall != 0) begin
            while (bus.data_ready !== 1'b1 && k < v.cycles + 200) begin
                @(negedge clk);
                k++;
            end
            ok = 1'b1;
            for (int s = 0; s < v.stall; s++) begin
                if (!(bus.data_ready === 1'b1 && bus.txd === 1'b1)) ok = 1'b0;
                if (s != v.stall - 1) begin
                    @(negedge clk);
                    k++;
                end
            end
            chk($sformatf("v%0d stall line idle/ready", id), 32'(ok), 32'd1);
            chk($sformatf("v%0d stall no handshake", id), 32'(hs_cnt - hs_base), 32'd0);
            src_hold = 1'b0;
        end

        while (bus.pkt_done !== 1'b1 && k < v.cycles + 200) begin
            @(negedge clk);
            k++;
            if (v.repulse && k == 50) begin
                bus.addr = 8'hFF; bus.len = 8'd7; bus.start = 1'b1;
            end
            if (v.repulse && k == 52) bus.start = 1'b0;
        end
        chk($sformatf("v%0d pkt_done seen", id), 32'(bus.pkt_done), 32'd1);
        chk($sformatf("v%0d start->done cycles", id), 32'(cyc - c0), 32'(v.cycles));

        if (v.start_done) begin
            bus.addr = v.addr; bus.len = 8'd0; bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d start at pkt_done ignored", id), 32'(bus.busy), 32'd0);
        end

        repeat (2) @(negedge clk);
        chk($sformatf("v%0d idle after", id), 32'(bus.busy), 32'd0);
        chk($sformatf("v%0d frames", id), 32'(rx_cnt - rx0), 32'(v.frames));
        chk($sformatf("v%0d handshakes", id), 32'(hs_cnt - hs_base), 32'(v.hs));
        chk($sformatf("v%0d byte_done pulses", id), 32'(bd_cnt - bd0), 32'(v.frames));
        chk($sformatf("v%0d pkt_done pulses", id), 32'(pd_cnt - pd0), 32'd1);
        chk($sformatf("v%0d stop bit errors", id), 32'(fe_cnt - fe0), 32'd0);

        ok = 1'b1;
        for (int i = 0; i < v.frames; i++) begin
            if (i == 0)      expb = v.addr;
            else if (i == 1) expb = v.ctrl;
            else if (i == 2) expb = v.len;
            else             expb = v.base + 8'(i - 3);
            if (rx_buf[(rx0 + i) % 1024] !== expb) ok = 1'b0;
        end
        chk($sformatf("v%0d byte contents", id), 32'(ok), 32'd1);
        src_en = 1'b0;
    endtask

    vec_t vecs [6];

    initial begin
        int         k;
        int         pd0;

        //            addr   ctrl   len     base  stall f0 rp sd frames hs  cycles
        vecs[0] = '{8'hA5, 8'h3C, 8'd0,   8'h01, 0,   1, 0, 0, 7,   4,   284};
        vecs[1] = '{8'h5A, 8'hC3, 8'd1,   8'h10, 100, 0, 0, 0, 9,   6,   466};
        vecs[2] = '{8'h11, 8'h22, 8'd2,   8'h40, 0,   0, 1, 0, 11,  8,   448};
        vecs[3] = '{8'h00, 8'hFF, 8'd0,   8'hF0, 0,   0, 0, 1, 7,   4,   284};
        vecs[4] = '{8'h81, 8'h7E, 8'd0,   8'h01, 0,   0, 0, 0, 7,   4,   284};
        vecs[5] = '{8'hC0, 8'hDE, 8'd255, 8'h00, 0,   0, 0, 0, 517, 514, 21194};

        bus.start = 1'b0; bus.addr = 8'h00; bus.ctrl = 8'h00; bus.len = 8'h00;

        // reset held: outputs quiet every cycle
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("reset cycle %0d {txd,busy,ready,bd,pd}", i),
                32'({bus.txd, bus.busy, bus.data_ready, bus.byte_done, bus.pkt_done}),
                32'b10000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                // abort mid DATA_BITS of body byte 2, then clean packet
                @(negedge clk);
                pd0 = pd_cnt;
                hs_base = hs_cnt; src_base = 8'h20; src_hold = 1'b0; src_en = 1'b1;
                @(posedge clk); #1;
                bus.addr = 8'h33; bus.ctrl = 8'h44; bus.len = 8'd0; bus.start = 1'b1;
                @(posedge clk); #1;
                bus.start = 1'b0;
                k = 0;
                while (hs_cnt - hs_base < 2 && k < 1000) begin
                    @(negedge clk);
                    k++;
                end
                chk("abort reached body byte 2", 32'(hs_cnt - hs_base), 32'd2);
                repeat (6) @(negedge clk);
                chk("abort in data bits busy", 32'(bus.busy), 32'd1);
                rst_n = 1'b0;
                #1;
                chk("abort {txd,busy,ready}", 32'({bus.txd, bus.busy, bus.data_ready}), 32'b100);
                src_en = 1'b0;
                repeat (5) @(negedge clk);
                chk("abort no pkt_done", 32'(pd_cnt - pd0), 32'd0);
                rst_n = 1'b1;
                repeat (3) @(negedge clk);
            end
            run_pkt(vecs[i], i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
